tty_writer: RTL

- Glass-TTY controller for port B of the 8 KB text frame store (dualmem, 64 rows x 128 columns, address = {row[5:0], col[6:0]}).
- Accepts a byte stream of characters over a valid/ready handshake and keeps a cursor.
- Writes printable characters, interprets CR/LF/BS/FF, and performs a hardware scroll-up when the cursor passes the last row.
- Arbitrates the same port against direct CPU byte accesses; sits in the msoc_clk domain between the CPU bus and the frame store.

---
 rtl/tty_writer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/tty_writer.sv
// tty_writer: glass-TTY front end for port B of the 64x128 text frame store.
// Round-robins a character stream (cursor, CR/LF/BS/FF, hardware scroll) against CPU byte accesses.
module tty_writer #(
  parameter int         COLS = 128,
  parameter int         ROWS = 64,
  parameter logic [7:0] FILL = 8'h20
) (
  input  logic        msoc_clk,
  input  logic        rstn,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [12:0] addrb,
  output logic [7:0]  dinb,
  input  logic [7:0]  doutb,
  output logic        web,
  output logic        enb,
  output logic [5:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam logic [6:0]  COL_MAX   = 7'(COLS - 1);
  localparam logic [5:0]  ROW_MAX   = 6'(ROWS - 1);
  localparam logic [12:0] ROW_BYTES = 13'(COLS);
  localparam logic [12:0] LAST_ROW  = 13'((ROWS - 1) * COLS);
  localparam logic [12:0] ADDR_LAST = 13'(ROWS * COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUT     = 3'd1,
    S_CPU_ISS = 3'd2,
    S_CPU_ACK = 3'd3,
    S_SCR_RD  = 3'd4,
    S_SCR_WR  = 3'd5,
    S_CLR     = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic        rr_chr_q, rr_chr_d;   // 1: last grant went to the character stream
  logic [5:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [7:0]  ch_q, ch_d;
  logic [12:0] cnt_q, cnt_d;         // scroll source address, or clear address
  logic        we_q, we_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        run_q;                // holds ch_ready low until the cycle after reset release
  logic        ch_take;
  logic        printable;
  logic        newline;

  assign cursor_row = row_q;
  assign cursor_col = col_q;

  // State, cursor and datapath registers
  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      rr_chr_q <= 1'b0;
      row_q    <= 6'd0;
      col_q    <= 7'd0;
      ch_q     <= 8'h00;
      cnt_q    <= 13'd0;
      we_q     <= 1'b0;
      rdata_q  <= 8'h00;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_chr_q <= rr_chr_d;
      row_q    <= row_d;
      col_q    <= col_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      run_q    <= 1'b1;
    end
  end

  // Arbitration, character decode, next state and frame-store port drive
  always_comb begin
    state_d   = state_q;
    rr_chr_d  = rr_chr_q;
    row_d     = row_q;
    col_d     = col_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    cpu_rdata = rdata_q;
    cpu_ack   = 1'b0;
    enb       = 1'b0;
    web       = 1'b0;
    addrb     = 13'd0;
    dinb      = 8'h00;
    newline   = 1'b0;
    busy      = (state_q != S_IDLE);
    ch_ready  = run_q & (state_q == S_IDLE) & ~(cpu_req & rr_chr_q);
    ch_take   = ch_valid & ch_ready;
    printable = (ch_data >= 8'h20) && (ch_data <= 8'h7E);

    case (state_q)
      S_IDLE: begin
        if (ch_take) begin
          rr_chr_d = 1'b1;
          if (printable) begin
            ch_d    = ch_data;
            state_d = S_PUT;
          end else begin
            case (ch_data)
              8'h0D: col_d = 7'd0;
              8'h0A: newline = 1'b1;
              8'h08: col_d = (col_q != 7'd0) ? (col_q - 7'd1) : col_q;
              8'h0C: begin
                row_d   = 6'd0;
                col_d   = 7'd0;
                cnt_d   = 13'd0;
                state_d = S_CLR;
              end
              default: col_d = col_q;
            endcase
          end
        end else if (cpu_req) begin
          rr_chr_d = 1'b0;
          we_d     = cpu_we;
          state_d  = S_CPU_ISS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PUT: begin
        enb     = 1'b1;
        web     = 1'b1;
        addrb   = {row_q, col_q};
        dinb    = ch_q;
        state_d = S_IDLE;
        if (col_q != COL_MAX) begin
          col_d = col_q + 7'd1;
        end else begin
          newline = 1'b1;
        end
      end
      S_CPU_ISS: begin
        enb     = 1'b1;
        web     = cpu_we;
        addrb   = cpu_addr;
        dinb    = cpu_wdata;
        state_d = S_CPU_ACK;
      end
      S_CPU_ACK: begin
        cpu_ack = 1'b1;
        state_d = S_IDLE;
        if (!we_q) begin
          cpu_rdata = doutb;
          rdata_d   = doutb;
        end else begin
          cpu_rdata = rdata_q;
        end
      end
      S_SCR_RD: begin
        enb     = 1'b1;
        addrb   = cnt_q;
        state_d = S_SCR_WR;
      end
      S_SCR_WR: begin
        enb   = 1'b1;
        web   = 1'b1;
        addrb = cnt_q - ROW_BYTES;
        dinb  = doutb;
        if (cnt_q == ADDR_LAST) begin
          cnt_d   = LAST_ROW;
          state_d = S_CLR;
        end else begin
          cnt_d   = cnt_q + 13'd1;
          state_d = S_SCR_RD;
        end
      end
      S_CLR: begin
        // Both clear ranges (last row, whole buffer) end on the top address
        enb   = 1'b1;
        web   = 1'b1;
        addrb = cnt_q;
        dinb  = FILL;
        if (cnt_q == ADDR_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (newline) begin
      col_d = 7'd0;
      if (row_q != ROW_MAX) begin
        row_d = row_q + 6'd1;
      end else begin
        cnt_d   = ROW_BYTES;
        state_d = S_SCR_RD;
      end
    end else begin
      row_d = row_d;
    end
  end

endmodule
